// File: rtl/fib_hash_arbiter_pkg.sv
// Shared types and widths for the FIB hash arbiter.
//   PREFIX_W / LEN_W / HASH_W : operand and result widths
//   req_id_e                  : requester identity (insert / lookup)
//   arb_state_e               : arbiter transaction state
//   hash_op_t                 : operand payload presented to the hash unit
package fib_hash_arbiter_pkg;

    localparam int unsigned PREFIX_W = 64;
    localparam int unsigned LEN_W    = 6;
    localparam int unsigned HASH_W   = 10;

    typedef enum logic {
        REQ_INS = 1'b0,
        REQ_LKP = 1'b1
    } req_id_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic [PREFIX_W-1:0] prefix;
        logic [LEN_W-1:0]    len;
    } hash_op_t;

    // The requester that gets priority after the given one finishes.
    function automatic req_id_e other_req(input req_id_e id);
        return (id == REQ_INS) ? REQ_LKP : REQ_INS;
    endfunction

endpackage

// File: rtl/fib_hash_arbiter_if.sv
// Bundle of requester and hash-unit signals around the FIB hash arbiter.
//   ins_* : insert requester  (req/prefix/len in, done/hash out)
//   lkp_* : lookup requester  (req/prefix/len in, done/hash out)
//   hash_prefix/hash_len out to the hash unit, hash_value back from it
//   busy  : arbiter has a transaction in flight
// slave modport is the arbiter side, master modport is the surrounding FIB side.
interface fib_hash_arbiter_if;
    import fib_hash_arbiter_pkg::*;

    logic                ins_req;
    logic [PREFIX_W-1:0] ins_prefix;
    logic [LEN_W-1:0]    ins_len;
    logic                ins_done;
    logic [HASH_W-1:0]   ins_hash;

    logic                lkp_req;
    logic [PREFIX_W-1:0] lkp_prefix;
    logic [LEN_W-1:0]    lkp_len;
    logic                lkp_done;
    logic [HASH_W-1:0]   lkp_hash;

    logic [PREFIX_W-1:0] hash_prefix;
    logic [LEN_W-1:0]    hash_len;
    logic [HASH_W-1:0]   hash_value;

    logic                busy;

    modport slave (
        input  ins_req, ins_prefix, ins_len,
        input  lkp_req, lkp_prefix, lkp_len,
        input  hash_value,
        output ins_done, ins_hash,
        output lkp_done, lkp_hash,
        output hash_prefix, hash_len,
        output busy
    );

    modport master (
        output ins_req, ins_prefix, ins_len,
        output lkp_req, lkp_prefix, lkp_len,
        output hash_value,
        input  ins_done, ins_hash,
        input  lkp_done, lkp_hash,
        input  hash_prefix, hash_len,
        input  busy
    );

endinterface

// File: rtl/fib_hash_arbiter_rr_arb2.sv
// Two-way round-robin winner select, purely combinational.
//   req_i     : request vector, bit 0 = insert, bit 1 = lookup
//   ptr_i     : requester that wins when both request
//   grant_c_o : one-hot grant (all zero when nobody requests)
module rr_arb2
    import fib_hash_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_id_e    ptr_i,
    output logic [1:0] grant_c_o
);

    always_comb begin
        grant_c_o = 2'b00;
        unique case (req_i)
            2'b01:   grant_c_o = 2'b01;
            2'b10:   grant_c_o = 2'b10;
            2'b11:   grant_c_o = (ptr_i == REQ_INS) ? 2'b01 : 2'b10;
            default: grant_c_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/fib_hash_arbiter.sv
// Shares one FIB hash unit between the insert and lookup paths, one
// transaction at a time: round-robin grant, latch operands onto the hash
// unit inputs, wait HASH_LAT cycles, return the hash with a one-cycle done.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (aborts any transaction in flight)
//   bus  : fib_hash_arbiter_if.slave (requesters, hash unit, busy)
// Parameter HASH_LAT (>= 1): cycles from hash inputs presented to hash_value valid.
module fib_hash_arbiter
    import fib_hash_arbiter_pkg::*;
#(
    parameter int unsigned HASH_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    fib_hash_arbiter_if.slave   bus
);

    localparam int unsigned     CNT_W    = (HASH_LAT > 1) ? $clog2(HASH_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HASH_LAT - 1);

    arb_state_e        state_q, state_d;
    req_id_e           owner_q, owner_d;
    req_id_e           rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    hash_op_t          op_q, op_d;
    logic [HASH_W-1:0] ins_hash_q, ins_hash_d;
    logic [HASH_W-1:0] lkp_hash_q, lkp_hash_d;
    logic              ins_done_q, ins_done_d;
    logic              lkp_done_q, lkp_done_d;
    logic              busy_q, busy_d;

    logic [1:0]        req_c;
    logic [1:0]        grant_c;

    assign req_c = {bus.lkp_req, bus.ins_req};

    rr_arb2 u_rr_arb2 (
        .req_i     (req_c),
        .ptr_i     (rr_ptr_q),
        .grant_c_o (grant_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|req_c) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered datapath and outputs.
    always_comb begin
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        ins_hash_d = ins_hash_q;
        lkp_hash_d = lkp_hash_q;
        ins_done_d = 1'b0;
        lkp_done_d = 1'b0;
        // busy mirrors the state the FSM is about to enter.
        busy_d     = (state_d != IDLE);

        unique case (state_q)
            IDLE: begin
                if (grant_c[0]) begin
                    owner_d     = REQ_INS;
                    op_d.prefix = bus.ins_prefix;
                    op_d.len    = bus.ins_len;
                end else if (grant_c[1]) begin
                    owner_d     = REQ_LKP;
                    op_d.prefix = bus.lkp_prefix;
                    op_d.len    = bus.lkp_len;
                end
            end
            ISSUE: begin
                cnt_d = CNT_LOAD;
            end
            WAIT: begin
                // Capture on the last wait cycle so done and hash appear together.
                if (cnt_q == '0) begin
                    if (owner_q == REQ_INS) begin
                        ins_hash_d = bus.hash_value;
                        ins_done_d = 1'b1;
                    end else begin
                        lkp_hash_d = bus.hash_value;
                        lkp_done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                rr_ptr_d = other_req(owner_q);
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= REQ_INS;
            rr_ptr_q   <= REQ_INS;
            cnt_q      <= '0;
            op_q       <= '0;
            ins_hash_q <= '0;
            lkp_hash_q <= '0;
            ins_done_q <= 1'b0;
            lkp_done_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            ins_hash_q <= ins_hash_d;
            lkp_hash_q <= lkp_hash_d;
            ins_done_q <= ins_done_d;
            lkp_done_q <= lkp_done_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.hash_prefix = op_q.prefix;
    assign bus.hash_len    = op_q.len;
    assign bus.ins_hash    = ins_hash_q;
    assign bus.lkp_hash    = lkp_hash_q;
    assign bus.ins_done    = ins_done_q;
    assign bus.lkp_done    = lkp_done_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_fib_hash_arbiter.sv
// Bench for fib_hash_arbiter: two instances (HASH_LAT=1 and HASH_LAT=3),
// each with a pipelined hash-unit model and a transaction-level reference.
module tb_fib_hash_arbiter;
    import fib_hash_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_d     [2];
    logic                ins_req_d [2];
    logic [PREFIX_W-1:0] ins_pfx_d [2];
    logic [LEN_W-1:0]    ins_len_d [2];
    logic                lkp_req_d [2];
    logic [PREFIX_W-1:0] lkp_pfx_d [2];
    logic [LEN_W-1:0]    lkp_len_d [2];

    logic en_cmp = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic logic [HASH_W-1:0] hfun(input logic [PREFIX_W-1:0] p,
                                               input logic [LEN_W-1:0] l);
        logic [63:0] x;
        x = (p ^ {58'd0, l}) * 64'h9E37_79B9_7F4A_7C15;
        return x[63:54] ^ HASH_W'(l);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int LAT = (g == 0) ? 1 : 3;

        fib_hash_arbiter_if bus ();

        assign bus.ins_req    = ins_req_d[g];
        assign bus.ins_prefix = ins_pfx_d[g];
        assign bus.ins_len    = ins_len_d[g];
        assign bus.lkp_req    = lkp_req_d[g];
        assign bus.lkp_prefix = lkp_pfx_d[g];
        assign bus.lkp_len    = lkp_len_d[g];

        fib_hash_arbiter #(.HASH_LAT(LAT)) dut (
            .clk (clk),
            .rst (rst_d[g]),
            .bus (bus)
        );

        // Hash unit: result for the inputs seen LAT edges ago.
        logic [HASH_W-1:0] pipe [LAT];
        always @(posedge clk) begin
            pipe[0] <= hfun(bus.hash_prefix, bus.hash_len);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign bus.hash_value = pipe[LAT-1];

        // Reference: a grant in cycle t completes in cycle t+LAT+2.
        bit                active  = 1'b0;
        int                own     = 0;
        int                ptr     = 0;
        int                mc      = 0;
        int                done_at = 0;
        logic [PREFIX_W-1:0] op_p  = '0;
        logic [LEN_W-1:0]  op_l    = '0;
        logic              e_busy, e_ins_done, e_lkp_done;
        logic [HASH_W-1:0] e_ins_hash, e_lkp_hash;
        logic [PREFIX_W-1:0] e_hp;
        logic [LEN_W-1:0]  e_hl;

        always @(posedge clk) begin
            if (rst_d[g]) begin
                active = 1'b0; ptr = 0;
                e_hp = '0; e_hl = '0; e_ins_hash = '0; e_lkp_hash = '0;
            end else if (!active) begin
                if (ins_req_d[g] || lkp_req_d[g]) begin
                    own     = (ins_req_d[g] && lkp_req_d[g]) ? ptr : (ins_req_d[g] ? 0 : 1);
                    op_p    = (own == 0) ? ins_pfx_d[g] : lkp_pfx_d[g];
                    op_l    = (own == 0) ? ins_len_d[g] : lkp_len_d[g];
                    e_hp    = op_p;
                    e_hl    = op_l;
                    active  = 1'b1;
                    done_at = mc + LAT + 2;
                end
            end else if (mc == done_at) begin
                active = 1'b0;
                ptr    = 1 - own;
            end
            mc++;
            e_busy     = active;
            e_ins_done = active && (mc == done_at) && (own == 0);
            e_lkp_done = active && (mc == done_at) && (own == 1);
            if (e_ins_done) e_ins_hash = hfun(op_p, op_l);
            if (e_lkp_done) e_lkp_hash = hfun(op_p, op_l);
        end
    end

    `define B0 gen_dut[0].bus
    `define B1 gen_dut[1].bus

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cmp_inst(input int k,
                            input logic a_busy, input logic e_busy,
                            input logic a_id, input logic e_id,
                            input logic a_ld, input logic e_ld,
                            input logic [HASH_W-1:0] a_ih, input logic [HASH_W-1:0] e_ih,
                            input logic [HASH_W-1:0] a_lh, input logic [HASH_W-1:0] e_lh,
                            input logic [PREFIX_W-1:0] a_hp, input logic [PREFIX_W-1:0] e_hp,
                            input logic [LEN_W-1:0] a_hl, input logic [LEN_W-1:0] e_hl);
        string p;
        p = (k == 0) ? "lat1" : "lat3";
        chk({p, "_busy"},        64'(a_busy), 64'(e_busy));
        chk({p, "_ins_done"},    64'(a_id),   64'(e_id));
        chk({p, "_lkp_done"},    64'(a_ld),   64'(e_ld));
        chk({p, "_ins_hash"},    64'(a_ih),   64'(e_ih));
        chk({p, "_lkp_hash"},    64'(a_lh),   64'(e_lh));
        chk({p, "_hash_prefix"}, a_hp,        e_hp);
        chk({p, "_hash_len"},    64'(a_hl),   64'(e_hl));
    endtask

    `define CMP_INST(K) cmp_inst(K, \
        gen_dut[K].bus.busy,        gen_dut[K].e_busy, \
        gen_dut[K].bus.ins_done,    gen_dut[K].e_ins_done, \
        gen_dut[K].bus.lkp_done,    gen_dut[K].e_lkp_done, \
        gen_dut[K].bus.ins_hash,    gen_dut[K].e_ins_hash, \
        gen_dut[K].bus.lkp_hash,    gen_dut[K].e_lkp_hash, \
        gen_dut[K].bus.hash_prefix, gen_dut[K].e_hp, \
        gen_dut[K].bus.hash_len,    gen_dut[K].e_hl)

    // One clock: compare both instances mid-cycle, then land just after the edge.
    task automatic step();
        @(negedge clk);
        if (en_cmp) begin
            `CMP_INST(0);
            `CMP_INST(1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs(input int k);
        ins_req_d[k] = 1'b0; ins_pfx_d[k] = '0; ins_len_d[k] = '0;
        lkp_req_d[k] = 1'b0; lkp_pfx_d[k] = '0; lkp_len_d[k] = '0;
    endtask

    task automatic do_reset(input int k);
        clear_inputs(k);
        rst_d[k] = 1'b1;
        step();
        step();
        rst_d[k] = 1'b0;
    endtask

    function automatic logic [LEN_W-1:0] pick_len();
        int r;
        r = int'($urandom_range(0, 3));
        if (r == 0) return '0;
        if (r == 1) return '1;
        return LEN_W'($urandom);
    endfunction

    localparam logic [PREFIX_W-1:0] PFX_A = 64'h0000_0000_DEAD_BEEF;
    localparam logic [PREFIX_W-1:0] PFX_B = 64'h0123_4567_89AB_CDEF;
    localparam logic [PREFIX_W-1:0] PFX_C = 64'hCAFE_F00D_1234_5678;
    localparam logic [PREFIX_W-1:0] PFX_D = 64'h8000_0000_0000_0001;

    int d_cyc [$];
    int d_who [$];

    initial begin
        for (int k = 0; k < 2; k++) begin
            clear_inputs(k);
            rst_d[k] = 1'b1;
        end
        @(posedge clk);
        #1;
        en_cmp = 1'b1;
        chk("rst_busy",      64'(`B0.busy),        64'd0);
        chk("rst_ins_done",  64'(`B0.ins_done),    64'd0);
        chk("rst_hash_pfx",  `B0.hash_prefix,      64'd0);
        chk("rst_lkp_hash",  64'(`B1.lkp_hash),    64'd0);
        step();
        rst_d[0] = 1'b0;
        rst_d[1] = 1'b0;
        step();

        // Single insert, latency 1.
        ins_req_d[0] = 1'b1; ins_pfx_d[0] = PFX_A; ins_len_d[0] = 6'd12;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 1) begin
                chk("d1_hash_prefix", `B0.hash_prefix,     PFX_A);
                chk("d1_hash_len",    64'(`B0.hash_len),   64'd12);
            end
            chk("d1_ins_done", 64'(`B0.ins_done), 64'(i == 3));
            chk("d1_lkp_done", 64'(`B0.lkp_done), 64'd0);
            if (i == 3) begin
                chk("d1_ins_hash", 64'(`B0.ins_hash), 64'(hfun(PFX_A, 6'd12)));
                ins_req_d[0] = 1'b0;
            end
        end

        // Simultaneous first requests after reset: insert first.
        do_reset(0);
        ins_req_d[0] = 1'b1; ins_pfx_d[0] = PFX_B; ins_len_d[0] = 6'd7;
        lkp_req_d[0] = 1'b1; lkp_pfx_d[0] = PFX_C; lkp_len_d[0] = 6'd33;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("d2_ins_done", 64'(`B0.ins_done), 64'(i == 3));
            chk("d2_lkp_done", 64'(`B0.lkp_done), 64'(i == 7));
            chk("d2_busy",     64'(`B0.busy),     64'((i >= 1 && i <= 3) || (i >= 5 && i <= 7)));
            if (i == 3) ins_req_d[0] = 1'b0;
            if (i == 7) lkp_req_d[0] = 1'b0;
        end

        // Both held for four transactions: strict alternation every 4 cycles.
        do_reset(0);
        ins_req_d[0] = 1'b1; ins_pfx_d[0] = PFX_D; ins_len_d[0] = 6'd63;
        lkp_req_d[0] = 1'b1; lkp_pfx_d[0] = PFX_A; lkp_len_d[0] = 6'd0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (`B0.ins_done === 1'b1) begin d_cyc.push_back(i); d_who.push_back(0); end
            if (`B0.lkp_done === 1'b1) begin d_cyc.push_back(i); d_who.push_back(1); end
        end
        chk("d3_count", 64'(d_cyc.size()), 64'd4);
        for (int j = 0; j < d_cyc.size(); j++) begin
            chk("d3_order", 64'(d_who[j]), 64'(j % 2));
            chk("d3_cycle", 64'(d_cyc[j]), 64'(3 + 4 * j));
        end
        ins_req_d[0] = 1'b0; lkp_req_d[0] = 1'b0;
        repeat (4) step();

        // Lookup pulsed for one cycle, operands changed after grant.
        do_reset(0);
        lkp_req_d[0] = 1'b1; lkp_pfx_d[0] = PFX_B; lkp_len_d[0] = 6'd40;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 1) begin
                lkp_req_d[0] = 1'b0; lkp_pfx_d[0] = '1; lkp_len_d[0] = 6'd5;
            end
            chk("d4_lkp_done", 64'(`B0.lkp_done), 64'(i == 3));
            chk("d4_ins_done", 64'(`B0.ins_done), 64'd0);
            chk("d4_busy",     64'(`B0.busy),     64'(i <= 3));
            if (i == 3) chk("d4_lkp_hash", 64'(`B0.lkp_hash), 64'(hfun(PFX_B, 6'd40)));
        end

        // Single lookup, latency 3.
        do_reset(1);
        lkp_req_d[1] = 1'b1; lkp_pfx_d[1] = PFX_C; lkp_len_d[1] = 6'd63;
        chk("d5_busy_t0", 64'(`B1.busy), 64'd0);
        for (int i = 1; i <= 7; i++) begin
            step();
            chk("d5_busy",     64'(`B1.busy),     64'(i <= 5));
            chk("d5_lkp_done", 64'(`B1.lkp_done), 64'(i == 5));
            if (i == 5) begin
                chk("d5_lkp_hash", 64'(`B1.lkp_hash), 64'(hfun(PFX_C, 6'd63)));
                lkp_req_d[1] = 1'b0;
            end
        end

        // Reset during WAIT of the lookup grant; next tie goes back to insert.
        do_reset(1);
        ins_req_d[1] = 1'b1; ins_pfx_d[1] = PFX_D; ins_len_d[1] = 6'd0;
        lkp_req_d[1] = 1'b1; lkp_pfx_d[1] = PFX_A; lkp_len_d[1] = 6'd63;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 9) rst_d[1] = 1'b1;
            if (i == 10) begin
                rst_d[1] = 1'b0;
                chk("d6_busy",     64'(`B1.busy),        64'd0);
                chk("d6_hash_pfx", `B1.hash_prefix,      64'd0);
                chk("d6_hash_len", 64'(`B1.hash_len),    64'd0);
                chk("d6_ins_hash", 64'(`B1.ins_hash),    64'd0);
                chk("d6_lkp_hash", 64'(`B1.lkp_hash),    64'd0);
            end
            chk("d6_lkp_done", 64'(`B1.lkp_done), 64'd0);
            chk("d6_ins_done", 64'(`B1.ins_done), 64'(i == 5 || i == 15));
            if (i == 15) chk("d6_ins_hash_after", 64'(`B1.ins_hash), 64'(hfun(PFX_D, 6'd0)));
        end
        clear_inputs(1);
        repeat (6) step();

        // Random traffic on both instances against the reference.
        repeat (4000) begin
            for (int k = 0; k < 2; k++) begin
                rst_d[k]     = ($urandom_range(0, 249) == 0);
                ins_req_d[k] = ($urandom_range(0, 99) < 50);
                lkp_req_d[k] = ($urandom_range(0, 99) < 50);
                if ($urandom_range(0, 3) == 0) begin
                    ins_pfx_d[k] = {$urandom, $urandom};
                    ins_len_d[k] = pick_len();
                end
                if ($urandom_range(0, 3) == 0) begin
                    lkp_pfx_d[k] = {$urandom, $urandom};
                    lkp_len_d[k] = pick_len();
                end
            end
            step();
        end

        for (int k = 0; k < 2; k++) begin
            clear_inputs(k);
            rst_d[k] = 1'b0;
        end
        repeat (8) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
